// File: rtl/mips_fsm_ctrl.sv
// Multi-cycle MIPS control FSM with a multi-beat instruction fetch.
// The instruction word is assembled from NBEAT = 32/WIDTH memory beats.
// Every output reads 0 while rst is low, even before the synchronous
// reset has been taken at the next rising edge.
module mips_fsm_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             op,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   memread,
  output logic                   memwrite,
  output logic                   alusrca,
  output logic                   memtoreg,
  output logic                   iord,
  output logic                   regwrite,
  output logic                   regdst,
  output logic                   pcen,
  output logic [1:0]             alusrcb,
  output logic [1:0]             pcsource,
  output logic [1:0]             aluop,
  output logic [(32/WIDTH)-1:0]  irwrite,
  output logic [3:0]             state,
  output logic                   illegal_op
);

  localparam int NBEAT = 32 / WIDTH;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(NBEAT - 1);
  localparam logic [NBEAT-1:0] BEAT_ONE  = NBEAT'(1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BW-1:0]     r_beat;
  logic [BW-1:0]     w_beat_next;

  logic              w_memread;
  logic              w_memwrite;
  logic              w_alusrca;
  logic              w_memtoreg;
  logic              w_iord;
  logic              w_regwrite;
  logic              w_regdst;
  logic              w_pcen;
  logic [1:0]        w_alusrcb;
  logic [1:0]        w_pcsource;
  logic [1:0]        w_aluop;
  logic [NBEAT-1:0]  w_irwrite;
  logic              w_illegal;

  // State and fetch-beat registers; reset wins over any pending memory handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      r_beat  <= w_beat_next;
    end
  end

  // Next-state and control decode; everything defaults to 0 / hold.
  always_comb begin
    w_next      = r_state;
    w_beat_next = r_beat;
    w_memread   = 1'b0;
    w_memwrite  = 1'b0;
    w_alusrca   = 1'b0;
    w_memtoreg  = 1'b0;
    w_iord      = 1'b0;
    w_regwrite  = 1'b0;
    w_regdst    = 1'b0;
    w_pcen      = 1'b0;
    w_alusrcb   = 2'b00;
    w_pcsource  = 2'b00;
    w_aluop     = 2'b00;
    w_irwrite   = '0;
    w_illegal   = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        if (mem_ready) begin
          w_irwrite = BEAT_ONE << r_beat;
          w_pcen    = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_beat_next = '0;
            w_next      = S_DECODE;
          end else begin
            w_beat_next = r_beat + 1'b1;
          end
        end
      end

      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (op)
          OP_LB, OP_SB: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_BNE:       w_next = S_BNEEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (op == OP_LB) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end
      end

      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
        w_next     = S_FETCH;
      end

      S_BEQEX: begin
        w_alusrca  = 1'b1;
        w_aluop    = 2'b01;
        w_pcsource = 2'b01;
        w_pcen     = zero;
        w_next     = S_FETCH;
      end

      S_BNEEX: begin
        w_alusrca  = 1'b1;
        w_aluop    = 2'b01;
        w_pcsource = 2'b01;
        w_pcen     = ~zero;
        w_next     = S_FETCH;
      end

      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end

      S_JEX: begin
        w_pcsource = 2'b10;
        w_pcen     = 1'b1;
        w_next     = S_FETCH;
      end

      default: begin
        w_next      = S_FETCH;
        w_beat_next = '0;
      end
    endcase
  end

  // Force all outputs low while reset is held, independent of the current state.
  always_comb begin
    memread    = rst & w_memread;
    memwrite   = rst & w_memwrite;
    alusrca    = rst & w_alusrca;
    memtoreg   = rst & w_memtoreg;
    iord       = rst & w_iord;
    regwrite   = rst & w_regwrite;
    regdst     = rst & w_regdst;
    pcen       = rst & w_pcen;
    alusrcb    = rst ? w_alusrcb  : 2'b00;
    pcsource   = rst ? w_pcsource : 2'b00;
    aluop      = rst ? w_aluop    : 2'b00;
    irwrite    = rst ? w_irwrite  : '0;
    state      = rst ? r_state    : 4'd0;
    illegal_op = rst & w_illegal;
  end

endmodule

// File: tb/tb_mips_fsm_ctrl.sv
// Scoreboard bench for mips_fsm_ctrl at WIDTH 8, 16 and 32.
// All three instances share the inputs; each directed vector names the
// instance it targets, and the monitor compares only that instance.
module tb_mips_fsm_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LB   = 6'b100000;
  localparam logic [5:0] SB   = 6'b101000;
  localparam logic [5:0] BAD  = 6'b111111;

  localparam logic [50:0] ZERO = 51'd0;

  // Per-instance outputs
  logic       mr8, mw8, asa8, m2r8, io8, rw8, rd8, pc8, ill8;
  logic [1:0] asb8, pcs8, aop8;
  logic [3:0] irw8, st8;
  logic       mr16, mw16, asa16, m2r16, io16, rw16, rd16, pc16, ill16;
  logic [1:0] asb16, pcs16, aop16, irw16;
  logic [3:0] st16;
  logic       mr32, mw32, asa32, m2r32, io32, rw32, rd32, pc32, ill32;
  logic [1:0] asb32, pcs32, aop32;
  logic [0:0] irw32;
  logic [3:0] st32;

  mips_fsm_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(mr8), .memwrite(mw8), .alusrca(asa8), .memtoreg(m2r8),
    .iord(io8), .regwrite(rw8), .regdst(rd8), .pcen(pc8),
    .alusrcb(asb8), .pcsource(pcs8), .aluop(aop8), .irwrite(irw8),
    .state(st8), .illegal_op(ill8));

  mips_fsm_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(mr16), .memwrite(mw16), .alusrca(asa16), .memtoreg(m2r16),
    .iord(io16), .regwrite(rw16), .regdst(rd16), .pcen(pc16),
    .alusrcb(asb16), .pcsource(pcs16), .aluop(aop16), .irwrite(irw16),
    .state(st16), .illegal_op(ill16));

  mips_fsm_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(mr32), .memwrite(mw32), .alusrca(asa32), .memtoreg(m2r32),
    .iord(io32), .regwrite(rw32), .regdst(rd32), .pcen(pc32),
    .alusrcb(asb32), .pcsource(pcs32), .aluop(aop32), .irwrite(irw32),
    .state(st32), .illegal_op(ill32));

  logic [50:0] obs8, obs16, obs32;
  assign obs8  = {st8,  ill8,  mr8,  mw8,  asa8,  m2r8,  io8,  rw8,  rd8,  pc8,
                  asb8,  pcs8,  aop8,  28'd0, irw8};
  assign obs16 = {st16, ill16, mr16, mw16, asa16, m2r16, io16, rw16, rd16, pc16,
                  asb16, pcs16, aop16, 30'd0, irw16};
  assign obs32 = {st32, ill32, mr32, mw32, asa32, m2r32, io32, rw32, rd32, pc32,
                  asb32, pcs32, aop32, 31'd0, irw32};

  logic [50:0] expQ[$];
  string       nameQ[$];
  int          selQ[$];
  int          sel;
  int          checks;
  int          errors;
  bit          done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector: {state, illegal, memread, memwrite, alusrca, memtoreg, iord,
  //          regwrite, regdst, pcen, alusrcb, pcsource, aluop, irwrite[31:0]}
  function automatic logic [50:0] mk(input logic [3:0] st, input logic ill,
      input logic mr, input logic mw, input logic asa, input logic m2r,
      input logic io, input logic rw, input logic rd, input logic pc,
      input logic [1:0] asb, input logic [1:0] pcs, input logic [1:0] aop,
      input logic [31:0] irw);
    return {st, ill, mr, mw, asa, m2r, io, rw, rd, pc, asb, pcs, aop, irw};
  endfunction

  function automatic logic [50:0] fetchE(input logic [31:0] irw, input logic pc);
    return mk(4'd0, 0, 1, 0, 0, 0, 0, 0, 0, pc, 2'b01, 2'b00, 2'b00, irw);
  endfunction

  function automatic logic [50:0] decodeE(input logic ill);
    return mk(4'd1, ill, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 32'd0);
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the expectation.
  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic z,
                               input logic m, input logic [50:0] e, input string nm);
    @(posedge clk);
    #1;
    rst       = r;
    op        = o;
    zero      = z;
    mem_ready = m;
    expQ.push_back(e);
    nameQ.push_back(nm);
    selQ.push_back(sel);
  endtask

  task automatic checkOutput(input logic [50:0] got, input logic [50:0] e,
                             input string nm);
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
    end
  endtask

  // Monitor: pop one expectation per cycle on the falling edge.
  initial begin
    logic [50:0] e;
    string       nm;
    int          s;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        s  = selQ.pop_front();
        case (s)
          0:       checkOutput(obs8,  e, nm);
          1:       checkOutput(obs16, e, nm);
          default: checkOutput(obs32, e, nm);
        endcase
      end
    end
  end

  initial begin
    rst = 1'b0; op = RT; zero = 1'b0; mem_ready = 1'b0;
    checks = 0; errors = 0; sel = 0; done = 0;

    // WIDTH=8 reset values, then R-type with 4-beat fetch
    applyStimulus(0, RT, 0, 0, ZERO, "rst_hold0");
    applyStimulus(0, RT, 0, 1, ZERO, "rst_hold1");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, RT, 0, 1, fetchE(32'd1 << i, 1), "a_fetch");
    applyStimulus(1, RT, 0, 1, decodeE(0), "a_decode");
    applyStimulus(1, RT, 0, 1, mk(4'd6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0), "a_rtypeex");
    applyStimulus(1, RT, 0, 1, mk(4'd7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0), "a_rtypewb");
    applyStimulus(1, RT, 0, 1, fetchE(32'd1, 1), "a_refetch");

    // WIDTH=8 LB with a fetch stall and a 3-cycle read wait
    applyStimulus(0, LB, 0, 1, ZERO, "b_rst");
    applyStimulus(1, LB, 0, 1, fetchE(32'd1, 1), "b_fetch0");
    applyStimulus(1, LB, 0, 0, fetchE(32'd0, 0), "b_fetch_stall");
    applyStimulus(1, LB, 0, 1, fetchE(32'd2, 1), "b_fetch1");
    applyStimulus(1, LB, 0, 1, fetchE(32'd4, 1), "b_fetch2");
    applyStimulus(1, LB, 0, 1, fetchE(32'd8, 1), "b_fetch3");
    applyStimulus(1, LB, 0, 1, decodeE(0), "b_decode");
    applyStimulus(1, LB, 0, 1, mk(4'd2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0), "b_memadr");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, LB, 0, 0, mk(4'd3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), "b_memrd_wait");
    applyStimulus(1, LB, 0, 1, mk(4'd3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), "b_memrd_done");
    applyStimulus(1, LB, 0, 1, mk(4'd4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0), "b_memwb");
    applyStimulus(1, LB, 0, 1, fetchE(32'd1, 1), "b_fetch_after");

    // WIDTH=32 single-beat fetch: branches, jump, addi, illegal opcode
    sel = 2;
    applyStimulus(0, BNE, 0, 1, ZERO, "c_rst");
    applyStimulus(1, BNE, 0, 1, fetchE(32'd1, 1), "c_fetch");
    applyStimulus(1, BNE, 0, 1, decodeE(0), "c_decode");
    applyStimulus(1, BNE, 0, 1, mk(4'd9, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0), "c_bne_taken");
    applyStimulus(1, BNE, 1, 1, fetchE(32'd1, 1), "c_fetch");
    applyStimulus(1, BNE, 1, 1, decodeE(0), "c_decode");
    applyStimulus(1, BNE, 1, 1, mk(4'd9, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0), "c_bne_not_taken");
    applyStimulus(1, BEQ, 1, 1, fetchE(32'd1, 1), "c_fetch");
    applyStimulus(1, BEQ, 1, 1, decodeE(0), "c_decode");
    applyStimulus(1, BEQ, 1, 1, mk(4'd8, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0), "c_beq_taken");
    applyStimulus(1, BEQ, 0, 1, fetchE(32'd1, 1), "c_fetch");
    applyStimulus(1, BEQ, 0, 1, decodeE(0), "c_decode");
    applyStimulus(1, BEQ, 0, 1, mk(4'd8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0), "c_beq_not_taken");
    applyStimulus(1, J, 0, 1, fetchE(32'd1, 1), "c_fetch");
    applyStimulus(1, J, 0, 1, decodeE(0), "c_decode");
    applyStimulus(1, J, 0, 1, mk(4'd12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0), "c_jex");
    applyStimulus(1, ADDI, 0, 1, fetchE(32'd1, 1), "c_fetch");
    applyStimulus(1, ADDI, 0, 1, decodeE(0), "c_decode");
    applyStimulus(1, ADDI, 0, 1, mk(4'd10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0), "c_addiex");
    applyStimulus(1, ADDI, 0, 1, mk(4'd11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0), "c_addiwb");
    applyStimulus(1, BAD, 0, 1, fetchE(32'd1, 1), "c_fetch");
    applyStimulus(1, BAD, 0, 1, decodeE(1), "c_illegal");
    applyStimulus(1, BAD, 0, 1, fetchE(32'd1, 1), "c_after_illegal");

    // WIDTH=16 reset asserted on fetch beat 1
    sel = 1;
    applyStimulus(0, RT, 0, 1, ZERO, "d_rst");
    applyStimulus(1, RT, 0, 1, fetchE(32'd1, 1), "d_fetch0");
    applyStimulus(0, RT, 0, 1, ZERO, "d_midfetch_rst");
    applyStimulus(1, RT, 0, 1, fetchE(32'd1, 1), "d_post_rst_b0");
    applyStimulus(1, RT, 0, 1, fetchE(32'd2, 1), "d_fetch1");
    applyStimulus(1, RT, 0, 1, decodeE(0), "d_decode");

    // WIDTH=8 SB with ready 0,0,1, then reset in the middle of a store
    sel = 0;
    applyStimulus(0, SB, 0, 1, ZERO, "e_rst");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, SB, 0, 1, fetchE(32'd1 << i, 1), "e_fetch");
    applyStimulus(1, SB, 0, 1, decodeE(0), "e_decode");
    applyStimulus(1, SB, 0, 1, mk(4'd2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0), "e_memadr");
    applyStimulus(1, SB, 0, 0, mk(4'd5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), "e_memwr_w0");
    applyStimulus(1, SB, 0, 0, mk(4'd5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), "e_memwr_w1");
    applyStimulus(1, SB, 0, 1, mk(4'd5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), "e_memwr_done");
    applyStimulus(1, SB, 0, 0, fetchE(32'd0, 0), "e_fetch_stall");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, SB, 0, 1, fetchE(32'd1 << i, 1), "e_fetch2");
    applyStimulus(1, SB, 0, 1, decodeE(0), "e_decode2");
    applyStimulus(1, SB, 0, 1, mk(4'd2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0), "e_memadr2");
    applyStimulus(1, SB, 0, 0, mk(4'd5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0), "e_memwr2");
    applyStimulus(0, SB, 0, 1, ZERO, "e_midstore_rst");
    applyStimulus(1, SB, 0, 0, fetchE(32'd0, 0), "e_post_rst_stall");
    applyStimulus(1, SB, 0, 1, fetchE(32'd1, 1), "e_post_rst_b0");

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 4 && expQ.size() > 0; i++)
      @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fsm_ctrl.md
MIPS_FSM_CTRL -- requirements
Module: mips_fsm_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, datapath/memory word width; legal values 8, 16, 32; NBEAT = 32/WIDTH is a derived local constant.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 op  input  6  opcode, instr[31:26].
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-007 memread, memwrite  output  1 each  memory strobes.
REQ-008 alusrca, memtoreg, iord, regwrite, regdst  output  1 each  datapath selects/enables.
REQ-009 pcen  output  1  PC register enable.
REQ-010 alusrcb, pcsource, aluop  output  2 each  datapath selects and ALU-op class.
REQ-011 irwrite  output  NBEAT  one-hot instruction-register beat enable.
REQ-012 state  output  4  current state code, debug.
REQ-013 illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-014 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, BNEEX=9, ADDIEX=10, ADDIWB=11, JEX=12.
REQ-015 Outputs SHALL be Moore (functions of state, beat count) except pcen, irwrite, and the FETCH pcwrite term, which also depend on mem_ready/zero.
REQ-016 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, pcsource=00, aluop=00; beat counter b (0..NBEAT-1) SHALL select irwrite bit b.
REQ-017 FETCH: irwrite[b] and pcen SHALL assert only in cycles with mem_ready=1; with mem_ready=0 memread stays high, b holds, no write.
REQ-018 FETCH: on mem_ready=1 with b<NBEAT-1, b increments; with b=NBEAT-1, b clears and next state is DECODE (NBEAT=1 means single-beat fetch).
REQ-019 DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target precompute); next state by op: 100000 LB/101000 SB->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 000101->BNEEX, 001000->ADDIEX, 000010->JEX.
REQ-020 DECODE with any other op: illegal_op=1 for that cycle, next state FETCH, no register/memory/PC write.
REQ-021 MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD if op=100000, else MEMWR.
REQ-022 MEMRD: memread=1, iord=1; hold until mem_ready=1, then MEMWB.
REQ-023 MEMWB: regwrite=1, memtoreg=1, regdst=0; next FETCH.
REQ-024 MEMWR: memwrite=1, iord=1; hold until mem_ready=1, then FETCH; memwrite SHALL not drop before the mem_ready cycle.
REQ-025 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next RTYPEWB. RTYPEWB: regwrite=1, regdst=1, memtoreg=0; next FETCH.
REQ-026 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcen=zero; next FETCH.
REQ-027 BNEEX: as BEQEX but pcen=~zero; next FETCH.
REQ-028 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0; next FETCH.
REQ-029 JEX: pcsource=10, pcen=1; next FETCH.
REQ-030 Any output not listed for a state SHALL be 0 in that state.
REQ-031 memread and memwrite SHALL never be high in the same cycle; regwrite and pcen never high in a memory-wait cycle.
REQ-032 Unreachable state codes (13-15) SHALL transition to FETCH with all outputs 0.

Reset
REQ-033 rst=0 at a rising edge SHALL set state=FETCH and b=0, regardless of state or pending mem_ready, including mid-fetch and mid-store.
REQ-034 While rst=0 all outputs SHALL be 0 (state output reads 0); first cycle after rst returns to 1 is FETCH b=0 with memread=1.

Verification
REQ-035 WIDTH=8, mem_ready=1, op=000000: 4 FETCH cycles with irwrite 0001,0010,0100,1000 and pcen=1 each, then DECODE, RTYPEEX (aluop=10), RTYPEWB (regwrite=1, regdst=1), FETCH; 7 cycles total.
REQ-036 WIDTH=8, LB, mem_ready held 0 for 3 cycles in MEMRD: memread=1, iord=1 for 4 cycles, then MEMWB regwrite=1, memtoreg=1.
REQ-037 WIDTH=32, BNE with zero=0 -> BNEEX pcen=1, pcsource=01; repeat with zero=1 -> pcen=0; FETCH is one beat, irwrite=1.
REQ-038 op=111111 -> DECODE pulses illegal_op=1 one cycle, next FETCH, no regwrite/memwrite/pcen.
REQ-039 WIDTH=16, rst=0 asserted on FETCH beat 1 with mem_ready=1: no irwrite that cycle after edge; post-reset FETCH b=0, irwrite=01.
REQ-040 SB with mem_ready toggling 0,0,1: memwrite high 3 cycles, then FETCH; memread never high concurrently.
